// File: rtl/layer_pkg.sv
// Shared definitions for the layer engines: DRAM memory map, FSM states,
// request tags and the saturate/ReLU output stage.
package layer_pkg;

    localparam int unsigned PARAM_BASE  = 0;
    localparam int unsigned POOL_BASE   = 65536;
    localparam int unsigned FC_BASE     = 131072;
    localparam int          Q_FRAC_BITS = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_BIAS,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } layer_state_t;

    // Kind of read issued last cycle, so the returning word can be routed.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_BIAS,
        TAG_ACT,
        TAG_WT
    } req_tag_t;

    // Clamp a signed value to a signed 'width'-bit range, then optionally zero negatives.
    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                    input int unsigned        width,
                                                    input logic               relu);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)      r = hi;
        else if (v < lo) r = lo;
        else             r = v;
        if (relu && (r < 64'sd0)) r = '0;
        return r;
    endfunction

endpackage

// File: rtl/fc_mac.sv
// Datapath of the FC engine: routes returning DRAM words by request tag into
// the bias/activation/product registers and accumulates one neuron.
module fc_mac
    import layer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 48,
    parameter int FRAC_BITS  = 16,
    parameter int RELU_EN    = 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  req_tag_t              req_tag,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] result
);

    req_tag_t                      tag_q;
    logic signed [DATA_WIDTH-1:0]  act_reg;
    logic signed [ACC_WIDTH-1:0]   prod_reg;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic                          prod_valid;
    logic signed [2*DATA_WIDTH-1:0] prod_full;
    logic signed [ACC_WIDTH-1:0]   prod_trunc;

    assign prod_full  = act_reg * $signed(data_in);
    assign prod_trunc = ACC_WIDTH'(prod_full >>> FRAC_BITS);

    always_ff @(posedge clk) begin
        if (srst) begin
            tag_q      <= TAG_NONE;
            act_reg    <= '0;
            prod_reg   <= '0;
            acc        <= '0;
            prod_valid <= 1'b0;
        end else begin
            tag_q      <= req_tag;
            prod_valid <= 1'b0;
            if (prod_valid) acc <= acc + prod_reg;
            // A dropped word (no dram_valid) is simply lost.
            if (dram_valid) begin
                case (tag_q)
                    TAG_BIAS: acc     <= ACC_WIDTH'($signed(data_in));
                    TAG_ACT:  act_reg <= data_in;
                    TAG_WT: begin
                        prod_reg   <= prod_trunc;
                        prod_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign result = DATA_WIDTH'(sat_relu({{(64-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc},
                                         DATA_WIDTH, RELU_EN != 0));

endmodule

// File: rtl/fc_layer.sv
// Fully-connected layer engine: per neuron loads the bias, streams
// activation/weight pairs through fc_mac, drains, and writes one result word.
module fc_layer
    import layer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int FRAC_BITS  = layer_pkg::Q_FRAC_BITS,
    parameter int ACC_WIDTH  = 48,
    parameter int IN_DEPTH   = 16,
    parameter int IN_DIM     = 5,
    parameter int OUT_LEN    = 10,
    parameter int RELU_EN    = 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  enable,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  dram_en_rd,
    output logic                  dram_en_wr,
    output logic                  done
);

    localparam int N  = IN_DEPTH * IN_DIM * IN_DIM;
    localparam int OW = $clog2(OUT_LEN + 1);
    localparam int IW = $clog2(N + 1);

    localparam logic [OW-1:0]         O_LAST    = OW'(OUT_LEN - 1);
    localparam logic [IW-1:0]         I_LAST    = IW'(N - 1);
    localparam logic [3:0]            DIM_LAST  = 4'(IN_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] BIAS_BASE = ADDR_WIDTH'(PARAM_BASE + OUT_LEN * N);
    localparam logic [ADDR_WIDTH-1:0] POOL_A    = ADDR_WIDTH'(POOL_BASE);
    localparam logic [ADDR_WIDTH-1:0] PARAM_A   = ADDR_WIDTH'(PARAM_BASE);
    localparam logic [ADDR_WIDTH-1:0] FC_A      = ADDR_WIDTH'(FC_BASE);

    layer_state_t          state, state_nxt;
    logic [OW-1:0]         o_cnt;
    logic [IW-1:0]         i_cnt;
    logic [3:0]            x_cnt, y_cnt, z_cnt;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  phase;
    logic                  drn;
    req_tag_t              req_tag;
    logic [DATA_WIDTH-1:0] result;

    fc_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .RELU_EN   (RELU_EN)
    ) u_mac (
        .clk       (clk),
        .srst      (srst),
        .req_tag   (req_tag),
        .dram_valid(dram_valid),
        .data_in   (data_in),
        .result    (result)
    );

    always_ff @(posedge clk) begin
        if (srst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Weights are contiguous across neurons, so w_addr just keeps counting.
    always_ff @(posedge clk) begin
        if (srst) begin
            o_cnt  <= '0;
            i_cnt  <= '0;
            x_cnt  <= '0;
            y_cnt  <= '0;
            z_cnt  <= '0;
            w_addr <= '0;
            phase  <= 1'b0;
            drn    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_cnt  <= '0;
                    w_addr <= '0;
                end
                S_LD_BIAS: begin
                    i_cnt <= '0;
                    x_cnt <= '0;
                    y_cnt <= '0;
                    z_cnt <= '0;
                    phase <= 1'b0;
                    drn   <= 1'b0;
                end
                S_MAC: begin
                    phase <= ~phase;
                    if (phase) begin
                        i_cnt  <= i_cnt + 1'b1;
                        w_addr <= w_addr + 1'b1;
                        if (x_cnt == DIM_LAST) begin
                            x_cnt <= '0;
                            if (y_cnt == DIM_LAST) begin
                                y_cnt <= '0;
                                z_cnt <= z_cnt + 1'b1;
                            end else begin
                                y_cnt <= y_cnt + 1'b1;
                            end
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: drn <= 1'b1;
                S_WRITE: if (o_cnt != O_LAST) o_cnt <= o_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        dram_en_rd = 1'b0;
        dram_en_wr = 1'b0;
        done       = 1'b0;
        addr_in    = '0;
        addr_out   = '0;
        data_out   = '0;
        req_tag    = TAG_NONE;
        case (state)
            S_IDLE: if (enable) state_nxt = S_LD_BIAS;
            S_LD_BIAS: begin
                dram_en_rd = 1'b1;
                addr_in    = BIAS_BASE + ADDR_WIDTH'(o_cnt);
                req_tag    = TAG_BIAS;
                state_nxt  = S_MAC;
            end
            S_MAC: begin
                dram_en_rd = 1'b1;
                if (phase) begin
                    addr_in = PARAM_A + w_addr;
                    req_tag = TAG_WT;
                    if (i_cnt == I_LAST) state_nxt = S_DRAIN;
                end else begin
                    addr_in = POOL_A + ADDR_WIDTH'({z_cnt, y_cnt, x_cnt});
                    req_tag = TAG_ACT;
                end
            end
            // Two idle cycles let the last product land and be accumulated.
            S_DRAIN: if (drn) state_nxt = S_WRITE;
            S_WRITE: begin
                dram_en_wr = 1'b1;
                addr_out   = FC_A + ADDR_WIDTH'(o_cnt);
                data_out   = result;
                state_nxt  = (o_cnt == O_LAST) ? S_DONE : S_LD_BIAS;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
